// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Word-organised data memory behind the core's load/store port. It takes one
// request at a time, waits a fixed number of wait states, performs the access,
// and presents a response held until the core accepts it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 4..4096)
//   LATENCY      wait-state cycles between acceptance and response (0..15)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  responder can accept (IDLE and rst low)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data, little-endian lanes
//   req_be     store byte enables, bit i selects bits [8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  core accepts the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    request was misaligned or out of range
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        commit;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_err;
    logic        wr_en;
    logic [AW-1:0] acc_idx;

    // With zero wait states the commit edge is the accept edge, so the access
    // must use the live request rather than the (not yet loaded) latches.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_idx = acc_addr[AW+1:2];
        // A full-word store may sit at any byte offset; everything else needs
        // word alignment.
        acc_err = ((acc_addr[1:0] != 2'b00) && (!acc_we || (acc_be != 4'hF)))
                || (acc_addr[31:2] >= DEPTH_L);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            err_d   = acc_err;
            rdata_d = (!acc_we && !acc_err) ? mem_q[acc_idx] : 32'd0;
        end
    end

    // Reset wins over a commit in the same cycle, so a store abandoned in
    // WAIT never reaches storage.
    assign wr_en = commit && acc_we && !acc_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders (LATENCY 2, 3 and 0, DEPTH_WORDS 16) share one clock.
// A transaction-level memory model predicts every response; a compare
// process checks each cycle a response is presented, and the request task
// checks latency, backpressure and handshake timing.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 16;
    localparam int NI    = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 3 : 0);
    endfunction

    logic        clk;
    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_be    [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be   (req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: memory image per instance plus the response expected now.
    logic [31:0] mdl_mem    [NI][DEPTH];
    logic [31:0] exp_rd     [NI];
    logic        exp_err    [NI];
    bit          exp_active [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void mdl_predict(input int k, input bit we, input logic [31:0] addr,
                                        input logic [3:0] be,
                                        output logic [31:0] rd, output logic err);
        int unsigned idx;
        bit mis, oor;
        idx = addr / 4;
        mis = ((addr % 4) != 0) && (!we || (be != 4'hF));
        oor = idx >= DEPTH;
        err = mis || oor;
        rd  = 32'd0;
        if (!err && !we) rd = mdl_mem[k][idx];
    endfunction

    function automatic void mdl_store(input int k, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be);
        logic [31:0] mask;
        int unsigned idx;
        idx  = addr / 4;
        mask = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        mdl_mem[k][idx] = (mdl_mem[k][idx] & ~mask) | (wdata & mask);
    endfunction

    // Every cycle a response is presented it must match the model, which
    // also catches values drifting during backpressure.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rsp_valid[k] === 1'b1) begin
                if (exp_active[k]) begin
                    chk($sformatf("rsp_rdata[%0d]", k), rsp_rdata[k], exp_rd[k]);
                    chk($sformatf("rsp_err[%0d]", k), {31'd0, rsp_err[k]}, {31'd0, exp_err[k]});
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_spurious[%0d]: got rsp_valid=1 expected 0 (t=%0t)", k, $time);
                end
            end
        end
    end

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (req_ready[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready[k] !== 1'b1) chk("ready_timeout", {31'd0, req_ready[k]}, 32'd1);
    endtask

    task automatic do_req(input int k, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          output logic [31:0] act_rd, output logic act_err);
        logic [31:0] e_rd;
        logic        e_err;
        int          n;
        bit          rdy_bad;
        rdy_bad = 1'b0;
        wait_ready(k);
        mdl_predict(k, we, addr, be, e_rd, e_err);
        exp_rd[k]     = e_rd;
        exp_err[k]    = e_err;
        exp_active[k] = 1'b1;
        req_valid[k]  = 1'b1;
        req_we[k]     = we;
        req_addr[k]   = addr;
        req_wdata[k]  = wdata;
        req_be[k]     = be;
        rsp_ready[k]  = (hold == 0);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
        chk("ready_low_after_accept", {31'd0, req_ready[k]}, 32'd0);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rsp_valid[k] === 1'b1) break;
            if (req_ready[k] !== 1'b0) rdy_bad = 1'b1;
        end
        chk($sformatf("latency[%0d]", k), n, lat_of(k) + 1);
        act_rd  = rsp_rdata[k];
        act_err = rsp_err[k];
        if (we && !e_err) mdl_store(k, addr, wdata, be);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid[k]}, 32'd1);
            chk("bp_ready", {31'd0, req_ready[k]}, 32'd0);
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        chk("rsp_done", {31'd0, rsp_valid[k]}, 32'd0);
        chk("idle_after", {31'd0, req_ready[k]}, 32'd1);
        chk("ready_low_in_wait", {31'd0, rdy_bad}, 32'd0);
        exp_active[k] = 1'b0;
    endtask

    task automatic rand_ops(input int k, input int count);
        logic [31:0] a, d, rd;
        logic [3:0]  be;
        logic        er;
        int          r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else a = $urandom_range(0, 4 * DEPTH + 3);
            if (r < 6) a[1:0] = 2'b00;
            be = (r < 4) ? 4'hF : 4'($urandom_range(0, 15));
            d  = $urandom;
            do_req(k, 1'($urandom_range(0, 1)), a, d, be, $urandom_range(0, 2), rd, er);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;

        for (int k = 0; k < NI; k++) begin
            rst[k]        = 1'b1;
            req_valid[k]  = 1'b1;
            req_we[k]     = 1'b1;
            req_addr[k]   = 32'h0;
            req_wdata[k]  = 32'h5555_AAAA;
            req_be[k]     = 4'hF;
            rsp_ready[k]  = 1'b1;
            exp_active[k] = 1'b0;
            exp_rd[k]     = 32'd0;
            exp_err[k]    = 1'b0;
        end

        // Reset held three cycles with a request pending.
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk("rst_req_ready", {31'd0, req_ready[k]}, 32'd0);
                chk("rst_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
                chk("rst_rsp_rdata", rsp_rdata[k], 32'd0);
                chk("rst_rsp_err", {31'd0, rsp_err[k]}, 32'd0);
            end
        end
        for (int k = 0; k < NI; k++) begin
            rst[k]       = 1'b0;
            req_valid[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < NI; k++) chk("ready_after_release", {31'd0, req_ready[k]}, 32'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("post_rst_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
            chk("post_rst_rsp_rdata", rsp_rdata[k], 32'd0);
        end

        // Initialise every word so all later loads are defined.
        for (int k = 0; k < NI; k++)
            for (int w = 0; w < DEPTH; w++)
                do_req(k, 1'b1, 32'(4 * w), $urandom, 4'hF, 0, rd, er);

        // Store/load round trip and byte enables on the LATENCY=2 instance.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
        chk("st_rdata", rd, 32'd0);
        chk("st_err", {31'd0, er}, 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("ld_deadbeef", rd, 32'hDEADBEEF);
        do_req(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("ld_be0101", rd, 32'hDE22BE44);
        chk("model_pin_be0101", mdl_mem[0][4], 32'hDE22BE44);
        do_req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er);
        chk("be0_err", {31'd0, er}, 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("ld_after_be0", rd, 32'hDE22BE44);

        // Error cases.
        do_req(0, 1'b0, 32'h12, 32'h0, 4'hF, 0, rd, er);
        chk("mis_ld_err", {31'd0, er}, 32'd1);
        chk("mis_ld_rdata", rd, 32'd0);
        do_req(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd, er);
        do_req(0, 1'b1, 32'(4 * DEPTH), 32'h12345678, 4'hF, 0, rd, er);
        chk("oor_st_err", {31'd0, er}, 32'd1);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
        chk("word0_unchanged", rd, 32'h0BADF00D);

        // Backpressure: four cycles of rsp_ready=0.
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 4, rd, er);
        chk("bp_load", rd, 32'hDE22BE44);

        // Reset in WAIT on the LATENCY=3 instance abandons the store.
        do_req(1, 1'b1, 32'h20, 32'h11111111, 4'hF, 0, rd, er);
        wait_ready(1);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'hCAFEF00D;
        req_be[1]    = 4'hF;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_valid", {31'd0, rsp_valid[1]}, 32'd0);
            chk("midrst_ready", {31'd0, req_ready[1]}, 32'd0);
        end
        rst[1] = 1'b0;
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("midrst_load", rd, 32'h11111111);

        // Reset in RESP drops the response but the store has committed.
        wait_ready(1);
        exp_rd[1]     = 32'd0;
        exp_err[1]    = 1'b0;
        exp_active[1] = 1'b1;
        rsp_ready[1]  = 1'b0;
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_addr[1]   = 32'h24;
        req_wdata[1]  = 32'h33333333;
        req_be[1]     = 4'hF;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rsp_valid[1] === 1'b1) break;
        end
        chk("resp_rst_latency", n, 4);
        mdl_store(1, 32'h24, 32'h33333333, 4'hF);
        rst[1] = 1'b1;
        @(negedge clk);
        chk("resp_rst_drop", {31'd0, rsp_valid[1]}, 32'd0);
        exp_active[1] = 1'b0;
        rst[1]        = 1'b0;
        rsp_ready[1]  = 1'b1;
        do_req(1, 1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er);
        chk("resp_rst_load", rd, 32'h33333333);

        // LATENCY=0: the latency check in do_req requires the response in
        // the cycle right after the accept.
        do_req(2, 1'b1, 32'h8, 32'hA5A5_5A5A, 4'hF, 0, rd, er);
        do_req(2, 1'b0, 32'h8, 32'h0, 4'h0, 1, rd, er);
        chk("lat0_load", rd, 32'hA5A5_5A5A);

        // Randomised traffic against the model.
        rand_ops(0, 80);
        rand_ops(1, 30);
        rand_ops(2, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
